// File: rtl/c2c_multi_reset_hndlr.sv
// -----------------------------------------------------------------------------
// c2c_multi_reset_hndlr
//
// Reset manager for NUM_CH chip-to-chip bridges that share one clock domain.
// Each channel runs its own supervisor FSM:
//   C2C_RST  : bridge held in reset for RST_CYCLES cycles
//   IDLE     : waiting for link-up (master channels also run a timeout)
//   LINK_UP  : link is up and healthy
//   LNKH_ACT : an external link handler owns the channel
//   FAULT    : too many consecutive failed bring-ups; held until cleared
// Consecutive failed bring-ups are counted per channel. When the count reaches
// MAX_RETRY the channel latches FAULT. Sticky per-channel error bits are kept
// for software.
//
// Parameters
//   NUM_CH      number of supervised channels (1..8)
//   FREQ        c2c_aclk frequency in Hz
//   DIV         link-up timeout is FREQ/DIV cycles (must come to at least 2)
//   RST_CYCLES  bridge reset pulse length in cycles (2..256)
//   MAX_RETRY   consecutive failed bring-ups before FAULT (1..15)
//
// Ports (per-channel vectors: bit i belongs to channel i)
//   c2c_aclk                in  clock, rising edge
//   c2c_areset              in  synchronous active-high reset
//   c2c_master              in  [NUM_CH]    channel is link master (enables timeout)
//   c2c_link_status         in  [NUM_CH]    bridge reports link up
//   c2c_config_error        in  [NUM_CH]    bridge configuration error
//   c2c_multi_bit_error     in  [NUM_CH]    bridge multi-bit error
//   c2c_link_error          in  [NUM_CH]    bridge link error
//   c2c_link_hndlr_in_prog  in  [NUM_CH]    external link handler active
//   c2c_clr_error           in  [NUM_CH]    pulse: clear sticky error status
//   c2c_clr_fault           in  [NUM_CH]    pulse: release channel from FAULT
//   c2c_aresetn_out         out [NUM_CH]    active-low bridge reset
//   c2c_link_up             out [NUM_CH]    channel is in LINK_UP
//   c2c_fault               out [NUM_CH]    channel is in FAULT
//   c2c_error_status        out [3*NUM_CH]  sticky {link, multi_bit, config}
//   c2c_retry_cnt           out [4*NUM_CH]  consecutive-failure count
//   c2c_all_link_up         out             every channel is in LINK_UP
// -----------------------------------------------------------------------------
module c2c_multi_reset_hndlr #(
    parameter int NUM_CH     = 2,
    parameter int FREQ       = 188000000,
    parameter int DIV        = 1000,
    parameter int RST_CYCLES = 8,
    parameter int MAX_RETRY  = 4
) (
    input  logic                  c2c_aclk,
    input  logic                  c2c_areset,
    input  logic [NUM_CH-1:0]     c2c_master,
    input  logic [NUM_CH-1:0]     c2c_link_status,
    input  logic [NUM_CH-1:0]     c2c_config_error,
    input  logic [NUM_CH-1:0]     c2c_multi_bit_error,
    input  logic [NUM_CH-1:0]     c2c_link_error,
    input  logic [NUM_CH-1:0]     c2c_link_hndlr_in_prog,
    input  logic [NUM_CH-1:0]     c2c_clr_error,
    input  logic [NUM_CH-1:0]     c2c_clr_fault,
    output logic [NUM_CH-1:0]     c2c_aresetn_out,
    output logic [NUM_CH-1:0]     c2c_link_up,
    output logic [NUM_CH-1:0]     c2c_fault,
    output logic [3*NUM_CH-1:0]   c2c_error_status,
    output logic [4*NUM_CH-1:0]   c2c_retry_cnt,
    output logic                  c2c_all_link_up
);

    // Timeout length is fixed at elaboration; the counter itself is 32 bits.
    localparam int          TIMEOUT   = FREQ / DIV;
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [31:0] RST_LOAD  = 32'(RST_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        C2C_RST  = 3'd0,
        IDLE     = 3'd1,
        LINK_UP  = 3'd2,
        LNKH_ACT = 3'd3,
        FAULT    = 3'd4
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        state_t      state_q, state_d;
        logic [31:0] cnt_q, cnt_d;      // reset-pulse countdown / IDLE timeout count
        logic [3:0]  retry_q, retry_d;
        logic [2:0]  sts_q, sts_d;
        logic [2:0]  err_vec;
        logic        err;
        logic        fail;

        assign err_vec = {c2c_link_error[i], c2c_multi_bit_error[i], c2c_config_error[i]};
        assign err     = |err_vec;

        always_ff @(posedge c2c_aclk) begin
            if (c2c_areset) begin
                state_q <= C2C_RST;
                cnt_q   <= RST_LOAD;
                retry_q <= '0;
                sts_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                retry_q <= retry_d;
                sts_q   <= sts_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            retry_d = retry_q;
            fail    = 1'b0;

            case (state_q)
                C2C_RST: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        cnt_d   = '0;     // timeout count starts fresh in IDLE
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end

                IDLE: begin
                    if (c2c_link_hndlr_in_prog[i]) begin
                        state_d = LNKH_ACT;
                    end else if (err) begin
                        fail = 1'b1;
                    end else if (c2c_link_status[i]) begin
                        state_d = LINK_UP;
                        retry_d = '0;
                    end else if (c2c_master[i]) begin
                        // Only masters time out; slaves wait forever for the link.
                        if (cnt_q == TMO_LAST) begin
                            fail = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                end

                LINK_UP: begin
                    if (c2c_link_hndlr_in_prog[i]) begin
                        state_d = LNKH_ACT;
                    end else if (err || !c2c_link_status[i]) begin
                        // Losing an established link is not a failed bring-up.
                        state_d = C2C_RST;
                        cnt_d   = RST_LOAD;
                        retry_d = '0;
                    end
                end

                LNKH_ACT: begin
                    if (!c2c_link_hndlr_in_prog[i]) begin
                        state_d = C2C_RST;
                        cnt_d   = RST_LOAD;
                    end
                end

                FAULT: begin
                    if (c2c_clr_fault[i]) begin
                        state_d = C2C_RST;
                        cnt_d   = RST_LOAD;
                        retry_d = '0;
                    end
                end

                default: begin
                    state_d = C2C_RST;
                    cnt_d   = RST_LOAD;
                end
            endcase

            // A failed bring-up either retries through reset or latches FAULT.
            if (fail) begin
                if (retry_q + 4'd1 == RETRY_MAX) begin
                    state_d = FAULT;
                    retry_d = RETRY_MAX;
                end else begin
                    state_d = C2C_RST;
                    cnt_d   = RST_LOAD;
                    retry_d = retry_q + 4'd1;
                end
            end
        end

        // Sticky status: an error arriving together with a clear still sets.
        always_comb begin
            if (c2c_clr_error[i]) begin
                sts_d = err_vec;
            end else begin
                sts_d = sts_q | err_vec;
            end
        end

        assign c2c_aresetn_out[i]        = !((state_q == C2C_RST) || (state_q == FAULT));
        assign c2c_link_up[i]            = (state_q == LINK_UP);
        assign c2c_fault[i]              = (state_q == FAULT);
        assign c2c_error_status[3*i +: 3] = sts_q;
        assign c2c_retry_cnt[4*i +: 4]    = retry_q;

    end : g_ch

    assign c2c_all_link_up = &c2c_link_up;

endmodule

// File: tb/tb_c2c_multi_reset_hndlr.sv
module tb_c2c_multi_reset_hndlr;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] master, link, cfg, mbe, lerr, inprog, clr_err, clr_flt;
    logic [1:0] rstn_o, linkup_o, fault_o;
    logic [5:0] sts_o;
    logic [7:0] retry_o;
    logic       all_o;

    always #5 clk = ~clk;

    c2c_multi_reset_hndlr #(
        .NUM_CH    (2),
        .FREQ      (100000),
        .DIV       (1000),
        .RST_CYCLES(8),
        .MAX_RETRY (4)
    ) dut (
        .c2c_aclk              (clk),
        .c2c_areset            (rst),
        .c2c_master            (master),
        .c2c_link_status       (link),
        .c2c_config_error      (cfg),
        .c2c_multi_bit_error   (mbe),
        .c2c_link_error        (lerr),
        .c2c_link_hndlr_in_prog(inprog),
        .c2c_clr_error         (clr_err),
        .c2c_clr_fault         (clr_flt),
        .c2c_aresetn_out       (rstn_o),
        .c2c_link_up           (linkup_o),
        .c2c_fault             (fault_o),
        .c2c_error_status      (sts_o),
        .c2c_retry_cnt         (retry_o),
        .c2c_all_link_up       (all_o)
    );

    localparam int F_RSTN = 0, F_LNK = 1, F_FLT = 2, F_STS = 3, F_RTY = 4, F_ALL = 5;

    typedef struct {
        string      tag;
        int         fld;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [7:0] observe(input int fld);
        case (fld)
            F_RSTN:  return {6'd0, rstn_o};
            F_LNK:   return {6'd0, linkup_o};
            F_FLT:   return {6'd0, fault_o};
            F_STS:   return {2'd0, sts_o};
            F_RTY:   return retry_o;
            F_ALL:   return {7'd0, all_o};
            default: return 8'hff;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int fld, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic push_reset_vals(input string tag);
        push_exp({tag, "_rstn"},  F_RSTN, 8'h00);
        push_exp({tag, "_lnk"},   F_LNK,  8'h00);
        push_exp({tag, "_flt"},   F_FLT,  8'h00);
        push_exp({tag, "_sts"},   F_STS,  8'h00);
        push_exp({tag, "_retry"}, F_RTY,  8'h00);
        push_exp({tag, "_all"},   F_ALL,  8'h00);
    endtask

    // Advance one clock, sample 1 time unit after the edge, drain the scoreboard.
    task automatic tick();
        exp_t       e;
        logic [7:0] o;
        @(posedge clk);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            o = observe(e.fld);
            n_tests++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, o, e.val);
            end
        end
    endtask

    // ch1 has just entered C2C_RST with retry 0, master, link down. Four
    // bring-up attempts of 8 reset + 100 idle cycles each, ending in FAULT.
    // ch0 sits in LINK_UP throughout.
    task automatic run_fault_ch1();
        for (int a = 0; a < 4; a++) begin
            for (int k = 1; k <= 107; k++) begin
                push_exp("tmo_rstn",   F_RSTN, (k < 8) ? 8'h01 : 8'h03);
                push_exp("tmo_retry",  F_RTY,  8'(a << 4));
                push_exp("tmo_ch0_up", F_LNK,  8'h01);
                tick();
            end
            if (a < 3) begin
                push_exp("tmo_fail_rstn",  F_RSTN, 8'h01);
                push_exp("tmo_fail_retry", F_RTY,  8'((a + 1) << 4));
                push_exp("tmo_fail_flt",   F_FLT,  8'h00);
            end else begin
                push_exp("fault_rstn",  F_RSTN, 8'h01);
                push_exp("fault_flt",   F_FLT,  8'h02);
                push_exp("fault_retry", F_RTY,  8'h40);
            end
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; master = '0; link = '0; cfg = '0; mbe = '0; lerr = '0;
        inprog = '0; clr_err = '0; clr_flt = '0;
        tick();
        tick();

        // Reset release: 8 cycles of bridge reset, then IDLE.
        push_reset_vals("rst_hold");
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            push_exp("rel_rstn", F_RSTN, 8'h00);
            tick();
        end
        push_exp("rel_idle_rstn",  F_RSTN, 8'h03);
        push_exp("rel_idle_lnk",   F_LNK,  8'h00);
        push_exp("rel_idle_retry", F_RTY,  8'h00);
        tick();

        link = 2'b01;
        push_exp("ch0_up_lnk",   F_LNK,  8'h01);
        push_exp("ch0_up_retry", F_RTY,  8'h00);
        push_exp("ch0_up_all",   F_ALL,  8'h00);
        push_exp("ch0_up_rstn",  F_RSTN, 8'h03);
        tick();
        link = 2'b11;
        push_exp("both_up_lnk", F_LNK, 8'h03);
        push_exp("both_up_all", F_ALL, 8'h01);
        tick();

        // Sticky error: multi-bit on ch1 in LINK_UP.
        mbe = 2'b10;
        push_exp("mbe_sts",   F_STS,  8'h10);
        push_exp("mbe_rstn",  F_RSTN, 8'h01);
        push_exp("mbe_lnk",   F_LNK,  8'h01);
        push_exp("mbe_all",   F_ALL,  8'h00);
        push_exp("mbe_retry", F_RTY,  8'h00);
        tick();
        mbe = '0;
        lerr = 2'b10; clr_err = 2'b10;
        push_exp("clr_set_sts",  F_STS,  8'h20);
        push_exp("clr_set_rstn", F_RSTN, 8'h01);
        tick();
        lerr = '0; clr_err = '0;
        push_exp("sticky_hold_sts", F_STS,  8'h20);
        push_exp("sticky_hold_rstn", F_RSTN, 8'h01);
        tick();
        clr_err = 2'b10;
        push_exp("clr_only_sts",  F_STS,  8'h00);
        push_exp("clr_only_rstn", F_RSTN, 8'h01);
        tick();
        clr_err = '0;
        for (int k = 4; k <= 7; k++) begin
            push_exp("mbe_rst_rstn", F_RSTN, 8'h01);
            tick();
        end
        push_exp("mbe_idle_rstn", F_RSTN, 8'h03);
        push_exp("mbe_idle_lnk",  F_LNK,  8'h01);
        tick();
        push_exp("mbe_reup_lnk",   F_LNK, 8'h03);
        push_exp("mbe_reup_all",   F_ALL, 8'h01);
        push_exp("mbe_reup_retry", F_RTY, 8'h00);
        tick();

        // Link handler on ch0.
        inprog = 2'b01;
        push_exp("lnkh_lnk",  F_LNK,  8'h02);
        push_exp("lnkh_rstn", F_RSTN, 8'h03);
        push_exp("lnkh_all",  F_ALL,  8'h00);
        tick();
        cfg = 2'b01; link = 2'b10;
        push_exp("lnkh_ign_lnk",  F_LNK,  8'h02);
        push_exp("lnkh_ign_rstn", F_RSTN, 8'h03);
        push_exp("lnkh_ign_sts",  F_STS,  8'h01);
        tick();
        cfg = '0; link = 2'b11;
        push_exp("lnkh_hold_rstn", F_RSTN, 8'h03);
        push_exp("lnkh_hold_lnk",  F_LNK,  8'h02);
        push_exp("lnkh_hold_sts",  F_STS,  8'h01);
        tick();
        inprog = '0; clr_err = 2'b01;
        push_exp("lnkh_drop_rstn", F_RSTN, 8'h02);
        push_exp("lnkh_drop_sts",  F_STS,  8'h00);
        push_exp("lnkh_drop_lnk",  F_LNK,  8'h02);
        tick();
        clr_err = '0;
        for (int k = 1; k <= 7; k++) begin
            push_exp("lnkh_rst_rstn", F_RSTN, 8'h02);
            tick();
        end
        push_exp("lnkh_idle_rstn", F_RSTN, 8'h03);
        push_exp("lnkh_idle_lnk",  F_LNK,  8'h02);
        tick();
        push_exp("lnkh_reup_lnk",   F_LNK, 8'h03);
        push_exp("lnkh_reup_all",   F_ALL, 8'h01);
        push_exp("lnkh_reup_retry", F_RTY, 8'h00);
        tick();

        // Timeout and fault on master ch1; ch0 stays up.
        master = 2'b10; link = 2'b01;
        push_exp("ch1_down_rstn",  F_RSTN, 8'h01);
        push_exp("ch1_down_retry", F_RTY,  8'h00);
        push_exp("ch1_down_lnk",   F_LNK,  8'h01);
        push_exp("ch1_down_all",   F_ALL,  8'h00);
        tick();
        run_fault_ch1();
        for (int k = 0; k < 40; k++) begin
            if (k == 20) link = 2'b11;
            push_exp("fault_hold_flt",   F_FLT,  8'h02);
            push_exp("fault_hold_rstn",  F_RSTN, 8'h01);
            push_exp("fault_hold_lnk",   F_LNK,  8'h01);
            push_exp("fault_hold_retry", F_RTY,  8'h40);
            tick();
        end
        link = 2'b01; clr_flt = 2'b10;
        push_exp("clrf_rstn",  F_RSTN, 8'h01);
        push_exp("clrf_flt",   F_FLT,  8'h00);
        push_exp("clrf_retry", F_RTY,  8'h00);
        push_exp("clrf_lnk",   F_LNK,  8'h01);
        tick();
        clr_flt = '0;
        run_fault_ch1();

        // Errors in FAULT only reach the sticky status.
        cfg = 2'b10;
        push_exp("flt_err_sts",  F_STS, 8'h08);
        push_exp("flt_err_flt",  F_FLT, 8'h02);
        push_exp("flt_err_lnk",  F_LNK, 8'h01);
        tick();
        cfg = '0;

        // Mid-operation reset while ch1 is in FAULT.
        rst = 1'b1;
        push_reset_vals("midrst");
        tick();
        rst = 1'b0; master = '0; link = '0;
        push_reset_vals("midrst_rel");
        tick();
        for (int k = 2; k <= 7; k++) begin
            push_exp("midrst_rstn", F_RSTN, 8'h00);
            tick();
        end
        push_exp("midrst_idle_rstn", F_RSTN, 8'h03);
        tick();

        // Slaves with link down never time out.
        for (int k = 0; k < 10000; k++) begin
            push_exp("slave_rstn",  F_RSTN, 8'h03);
            push_exp("slave_retry", F_RTY,  8'h00);
            push_exp("slave_lnk",   F_LNK,  8'h00);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/c2c_multi_reset_hndlr.md
# c2c_multi_reset_hndlr

Parametrised, multi-channel chip-to-chip (C2C) link reset manager. It supervises NUM_CH independent C2C bridges sharing one clock domain. Per channel it generates timed bridge resets, applies a link-up timeout on master channels, and bounds consecutive failed bring-ups with a retry limit that latches a fault. It also keeps sticky per-channel error status for the microblaze register interface, and sits between the C2C bridge IP instances and the control/status register block.

## Interface
Parameters:
- NUM_CH, 2: number of supervised channels (1–8).
- FREQ, 188000000: c2c_aclk frequency in Hz.
- DIV, 1000: timeout = FREQ/DIV cycles (default 1 ms).
- RST_CYCLES, 8: reset pulse length in cycles (2–256).
- MAX_RETRY, 4: consecutive failed bring-ups before fault (1–15).

Ports (all per-channel vectors are [NUM_CH-1:0], bit i = channel i):
- c2c_aclk  in  1  single clock; all logic is rising-edge.
- c2c_areset  in  1  synchronous, active-high reset.
- c2c_master  in  NUM_CH  channel is link master; enables the timeout.
- c2c_link_status  in  NUM_CH  bridge link up.
- c2c_config_error / c2c_multi_bit_error / c2c_link_error  in  NUM_CH each  bridge error strobes/levels.
- c2c_link_hndlr_in_prog  in  NUM_CH  external link handler owns the channel.
- c2c_clr_error  in  NUM_CH  one-cycle pulse; clears channel sticky status.
- c2c_clr_fault  in  NUM_CH  one-cycle pulse; releases channel from FAULT.
- c2c_aresetn_out  out  NUM_CH  active-low bridge reset.
- c2c_link_up  out  NUM_CH  channel in LINK_UP.
- c2c_fault  out  NUM_CH  channel in FAULT.
- c2c_error_status  out  3*NUM_CH  sticky {link, multi_bit, config} per channel; channel i at [3i+2:3i].
- c2c_retry_cnt  out  4*NUM_CH  consecutive-failure count; channel i at [4i+3:4i].
- c2c_all_link_up  out  1  AND of c2c_link_up.

## Operation
- Per-channel FSM states: C2C_RST, IDLE, LINK_UP, LNKH_ACT, FAULT. Channels are fully independent.
- err_i = config | multi_bit | link error of channel i.
- C2C_RST: counter loaded RST_CYCLES-1 on entry, decrements each cycle; at 0 → IDLE.
- IDLE, in priority order:
  - in_prog → LNKH_ACT.
  - err_i → fail.
  - link_status → LINK_UP, retry_cnt := 0.
  - master & timeout counter == TIMEOUT-1 → fail.
  - Timeout counter clears on IDLE entry and increments each IDLE cycle while master & ~link_status. Slaves never time out.
- fail: retry_cnt+1 == MAX_RETRY → FAULT, retry_cnt := MAX_RETRY; else → C2C_RST, retry_cnt += 1.
- LINK_UP, in priority order: in_prog → LNKH_ACT; err_i or ~link_status → C2C_RST, retry_cnt := 0.
- LNKH_ACT: ~in_prog → C2C_RST; retry_cnt unchanged; errors ignored.
- FAULT: held until clr_fault pulse → C2C_RST, retry_cnt := 0. All other inputs are ignored.
- Output decode is combinational from the state register (no extra flop):
  - aresetn_out = 0 in C2C_RST and FAULT, else 1.
  - link_up = (state == LINK_UP).
  - fault = (state == FAULT).
- Sticky status: each bit ORs in its error input every cycle in every state. clr_error clears; a set in the same cycle wins.
- TIMEOUT = FREQ/DIV, computed at elaboration. The counter is 32 bits wide. TIMEOUT must be ≥ 2.

## Timing
- During c2c_areset and the cycle after release, every channel is reset as follows:
  - state = C2C_RST, counter = RST_CYCLES-1.
  - aresetn_out = 0, link_up = 0, fault = 0.
  - error_status = 0, retry_cnt = 0, all_link_up = 0.
- After c2c_areset deasserts, aresetn_out stays low exactly RST_CYCLES cycles, then goes high.
- Each C2C_RST visit holds aresetn_out low exactly RST_CYCLES cycles.
- Input-to-state latency is 1 cycle. Output changes the cycle the state changes.
- A master with link down spends exactly TIMEOUT cycles in IDLE before failing.
- Sticky status appears 1 cycle after the error input. A clear takes effect 1 cycle after the clr pulse.
- c2c_areset mid-operation (any state, including FAULT) returns to the reset values on the next edge. Sticky status and retry count are lost.

## Test plan
- Reset release, NUM_CH=2, RST_CYCLES=8:
  - aresetn_out = 2'b00 for 8 cycles after deassert, then 2'b11.
  - ch0 link_status=1 in IDLE → link_up[0]=1 next cycle, retry_cnt ch0=0, all_link_up=0.
  - ch1 link up → all_link_up=1.
- Timeout and fault, FREQ=100000, DIV=1000, MAX_RETRY=4, master=1, link held down:
  - IDLE lasts 100 cycles, then C2C_RST with retry_cnt=1.
  - 4th failure → fault=1, aresetn_out low indefinitely.
  - clr_fault pulse → 8-cycle reset, retry_cnt=0.
- Slave, link down for 10000 cycles → stays IDLE, aresetn_out=1, retry_cnt=0.
- Sticky error:
  - 1-cycle multi_bit_error on ch1 in LINK_UP → status[4]=1, ch1 to C2C_RST, retry_cnt stays 0.
  - clr_error[1] with link_error[1] in the same cycle → status[5:3]=3'b100.
- Link handler: in_prog in LINK_UP → LNKH_ACT, aresetn_out=1, link_up=0, errors ignored; in_prog drop → aresetn_out low 8 cycles.
- Independence and mid-op reset:
  - ch1 in FAULT does not disturb ch0 LINK_UP.
  - c2c_areset pulse while ch1 in FAULT → all outputs return to their reset values next cycle.
